// File: rtl/sirv_gnrl_vr_fifo.sv
// Resettable load-enable flop for control state; clears to 0 on rst_n low.
// Latency: 1 cycle from i_lden/i_dnxt to o_qout.
// Backpressure: none; loads whenever i_lden is high.
module sirv_gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_lden,
    input  logic [DW-1:0] i_dnxt,
    output logic [DW-1:0] o_qout
);
    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_lden) begin
            r_q <= i_dnxt;
        end
    end

    assign o_qout = r_q;
endmodule

// Non-reset load-enable flop for datapath storage.
// Latency: 1 cycle from i_lden/i_dnxt to o_qout.
// Backpressure: none; loads whenever i_lden is high.
module sirv_gnrl_dffl #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          i_lden,
    input  logic [DW-1:0] i_dnxt,
    output logic [DW-1:0] o_qout
);
    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_lden) begin
            r_q <= i_dnxt;
        end
    end

    assign o_qout = r_q;
endmodule

// Valid/ready FIFO of DP entries (any depth 1..16), oldest entry presented downstream.
// Latency: a beat pushed at edge N is visible after edge N; no input-to-output bypass.
// Backpressure: i_rdy = not full, from registered count only; a same-cycle pop does not re-open it.
module sirv_gnrl_vr_fifo #(
    parameter int DP = 4,
    parameter int DW = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vld,
    output logic                    i_rdy,
    input  logic [DW-1:0]           i_dat,
    output logic                    o_vld,
    input  logic                    o_rdy,
    output logic [DW-1:0]           o_dat,
    output logic [$clog2(DP+1)-1:0] cnt
);
    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = $clog2(DP + 1);

    logic [PW-1:0] w_wptr;
    logic [PW-1:0] w_rptr;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_cnt_en;
    logic [DW-1:0] w_mem [DP];

    assign w_full  = (w_cnt == CW'(DP));
    assign w_empty = (w_cnt == '0);
    assign w_push  = i_vld & ~w_full;
    assign w_pop   = ~w_empty & o_rdy;

    // Explicit wrap so non-power-of-two depths stay within 0..DP-1.
    assign w_wptr_nxt = (w_wptr == PW'(DP - 1)) ? '0 : w_wptr + PW'(1);
    assign w_rptr_nxt = (w_rptr == PW'(DP - 1)) ? '0 : w_rptr + PW'(1);

    assign w_cnt_en  = w_push ^ w_pop;
    assign w_cnt_nxt = w_push ? (w_cnt + CW'(1)) : (w_cnt - CW'(1));

    sirv_gnrl_dfflr #(.DW(PW)) u_wptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lden (w_push),
        .i_dnxt (w_wptr_nxt),
        .o_qout (w_wptr)
    );

    sirv_gnrl_dfflr #(.DW(PW)) u_rptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lden (w_pop),
        .i_dnxt (w_rptr_nxt),
        .o_qout (w_rptr)
    );

    sirv_gnrl_dfflr #(.DW(CW)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lden (w_cnt_en),
        .i_dnxt (w_cnt_nxt),
        .o_qout (w_cnt)
    );

    for (genvar gi = 0; gi < DP; gi++) begin : g_mem
        sirv_gnrl_dffl #(.DW(DW)) u_ram (
            .clk    (clk),
            .i_lden (w_push && (w_wptr == PW'(gi))),
            .i_dnxt (i_dat),
            .o_qout (w_mem[gi])
        );
    end

    always_comb begin
        o_dat = w_mem[0];
        for (int i = 1; i < DP; i++) begin
            if (w_rptr == PW'(i)) begin
                o_dat = w_mem[i];
            end
        end
    end

    assign i_rdy = ~w_full;
    assign o_vld = ~w_empty;
    assign cnt   = w_cnt;
endmodule
